pio_irq_service_master: RTL and testbench

Avalon-MM initiator that services a 1-bit PIO input slave: the G-sensor interrupt PIO with registers data@0, irq_mask@2 and edge_capture@3.
- After reset it programs the slave's irq mask and clears its edge capture.
- On each interrupt it reads edge_capture, then data, then clears edge_capture.
- It delivers each serviced event on a valid/ready stream to the downstream consumer.
- It replaces CPU interrupt servicing of the G-sensor PIO in the SOPC fabric.

---
 rtl/pio_irq_service_master.sv | 192 +++++++++++++++++++
 tb/tb_pio_irq_service_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_irq_service_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pio_irq_service_master                                       |
// | Description : Avalon-MM initiator servicing the G-sensor IRQ PIO and       |
// |               streaming each serviced event. Optional PIO_SVC_TIMESTAMP_EN |
// |               adds a 32-bit cycle timestamp per event.                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pio_irq_service_master #(
    parameter logic [31:0] IRQ_MASK_VAL = 32'd1,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  m_address,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    input  logic        irq_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_data,
    output logic [15:0] evt_count,
    output logic [7:0]  missed,
    output logic        busy
`ifdef PIO_SVC_TIMESTAMP_EN
    ,
    output logic [31:0] evt_timestamp
`endif
);

    typedef enum logic [2:0] {
        INIT_MASK = 3'd0,
        INIT_CLR  = 3'd1,
        WAIT_IRQ  = 3'd2,
        RD_EDGE   = 3'd3,
        RD_DATA   = 3'd4,
        ACK       = 3'd5,
        EMIT      = 3'd6,
        WAIT_LOW  = 3'd7
    } state_t;

    localparam logic [1:0] c_rd_lat = 2'(READ_LATENCY);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_cnt, w_cnt_nxt;
    logic        r_edge_bit, r_data_bit, r_irq_q;
    logic        w_issue, w_issue_wr, w_cap_edge, w_cap_data, w_valid_nxt, w_handshake, w_start;
    logic [1:0]  w_issue_addr;
    logic [31:0] w_issue_wdata;
    logic        w_irq_rise;
    logic        w_unused_rdata;

    assign w_unused_rdata = ^m_readdata[31:1];
    assign w_irq_rise     = irq_in & ~r_irq_q;
    assign evt_data       = {r_edge_bit, r_data_bit};

    // Bus outputs are registered: the access decided in a state appears on the bus
    // the cycle after, so reset can hold every output at its idle value.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_issue       = 1'b0;
        w_issue_wr    = 1'b0;
        w_issue_addr  = m_address;
        w_issue_wdata = m_writedata;
        w_cap_edge    = 1'b0;
        w_cap_data    = 1'b0;
        w_valid_nxt   = evt_valid;
        w_handshake   = 1'b0;
        w_start       = 1'b0;
        case (r_state)
            INIT_MASK: begin
                w_issue       = 1'b1;
                w_issue_wr    = 1'b1;
                w_issue_addr  = 2'd2;
                w_issue_wdata = IRQ_MASK_VAL;
                w_state_nxt   = INIT_CLR;
            end
            INIT_CLR: begin
                w_issue       = 1'b1;
                w_issue_wr    = 1'b1;
                w_issue_addr  = 2'd3;
                w_issue_wdata = 32'd0;
                w_state_nxt   = WAIT_IRQ;
            end
            WAIT_IRQ: begin
                if (irq_in && enable) begin
                    w_issue      = 1'b1;
                    w_issue_addr = 2'd3;
                    w_cnt_nxt    = 2'd0;
                    w_start      = 1'b1;
                    w_state_nxt  = RD_EDGE;
                end
            end
            RD_EDGE: begin
                if (r_cnt == c_rd_lat) begin
                    w_cap_edge   = 1'b1;
                    w_issue      = 1'b1;
                    w_issue_addr = 2'd0;
                    w_cnt_nxt    = 2'd0;
                    w_state_nxt  = RD_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            RD_DATA: begin
                if (r_cnt == c_rd_lat) begin
                    w_cap_data    = 1'b1;
                    w_issue       = 1'b1;
                    w_issue_wr    = 1'b1;
                    w_issue_addr  = 2'd3;
                    w_issue_wdata = 32'd0;
                    w_state_nxt   = ACK;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            ACK: begin
                w_valid_nxt = 1'b1;
                w_state_nxt = EMIT;
            end
            EMIT: begin
                if (evt_ready) begin
                    w_handshake = 1'b1;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!irq_in) w_state_nxt = WAIT_IRQ;
            end
            default: w_state_nxt = INIT_MASK;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= INIT_MASK;
            r_cnt        <= 2'd0;
            r_edge_bit   <= 1'b0;
            r_data_bit   <= 1'b0;
            r_irq_q      <= 1'b0;
            m_address    <= 2'd0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= 32'd0;
            evt_valid    <= 1'b0;
            evt_count    <= 16'd0;
            missed       <= 8'd0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_irq_q      <= irq_in;
            m_chipselect <= w_issue;
            m_write_n    <= ~(w_issue & w_issue_wr);
            if (w_issue) begin
                m_address   <= w_issue_addr;
                m_writedata <= w_issue_wdata;
            end
            if (w_cap_edge) r_edge_bit <= m_readdata[0];
            if (w_cap_data) r_data_bit <= m_readdata[0];
            evt_valid <= w_valid_nxt;
            if (w_handshake) evt_count <= evt_count + 16'd1;
            if (w_irq_rise && (r_state != WAIT_IRQ) && (missed != 8'hFF))
                missed <= missed + 8'd1;
            busy <= (w_state_nxt != WAIT_IRQ);
        end
    end

`ifdef PIO_SVC_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts_cnt      <= 32'd0;
            evt_timestamp <= 32'd0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_start) evt_timestamp <= r_ts_cnt;
        end
    end
`else
    logic w_unused_start;
    assign w_unused_start = w_start;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pio_irq_service_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pio_irq_service_master                                    |
// | Description : Scoreboard bench with a registered-readdata PIO slave model. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pio_irq_service_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        irq_in = 1'b0;
    logic        evt_ready = 1'b0;
    logic [1:0]  m_address;
    logic        m_chipselect, m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;
    logic        evt_valid;
    logic [1:0]  evt_data;
    logic [15:0] evt_count;
    logic [7:0]  missed;
    logic        busy;
`ifdef PIO_SVC_TIMESTAMP_EN
    logic [31:0] evt_timestamp;
`endif

    int checks = 0;
    int failures = 0;
    int acc_seen = 0;
    logic        s_edge = 1'b0, s_data = 1'b0;
    logic [31:0] s_mask = '0;
    logic [31:0] tb_cyc;
    logic [34:0] acc_q[$];
    logic [1:0]  evt_q[$];

    pio_irq_service_master #(.IRQ_MASK_VAL(32'd1), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .irq_in(irq_in),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .evt_count(evt_count), .missed(missed), .busy(busy)
`ifdef PIO_SVC_TIMESTAMP_EN
        , .evt_timestamp(evt_timestamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] acc(input logic [1:0] a, input logic wr, input logic [31:0] d);
        return {a, wr, wr ? d : 32'd0};
    endfunction

    task automatic push_service(input logic e, input logic d);
        acc_q.push_back(acc(2'd3, 1'b0, 32'd0));
        acc_q.push_back(acc(2'd0, 1'b0, 32'd0));
        acc_q.push_back(acc(2'd3, 1'b1, 32'd0));
        evt_q.push_back({e, d});
    endtask

    task automatic wait_count(input logic [15:0] target, input string tag);
        int n = 0;
        while (evt_count !== target && n < 40) begin
            tick(1);
            n++;
        end
        check(tag, evt_count, target);
    endtask

    // Slave: registered readdata with junk upper bits; only bit 0 is meaningful.
    always @(posedge clk) begin
        if (m_chipselect && m_write_n) begin
            case (m_address)
                2'd0:    m_readdata <= {31'h2AAAAAAA, s_data};
                2'd2:    m_readdata <= s_mask;
                2'd3:    m_readdata <= {31'h2AAAAAAA, s_edge};
                default: m_readdata <= '0;
            endcase
        end
        if (m_chipselect && !m_write_n && m_address == 2'd2) s_mask <= m_writedata;
    end

    always @(posedge clk or negedge reset_n)
        if (!reset_n) tb_cyc <= '0;
        else          tb_cyc <= tb_cyc + 32'd1;

    always @(negedge clk) begin
        if (reset_n && m_chipselect) begin
            acc_seen++;
            if (acc_q.size() == 0) check("acc_unexpected", 35'(acc_q.size()), 35'd1);
            else check("acc", acc(m_address, ~m_write_n, m_writedata), acc_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            if (evt_q.size() == 0) check("evt_unexpected", 35'(evt_q.size()), 35'd1);
            else check("evt_data", evt_data, evt_q.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [31:0] ts_exp;

        // Reset state
        tick(3);
        check("reset_out", {m_chipselect, m_write_n, busy, evt_valid, evt_data, m_address},
              {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
        check("reset_cnt", {evt_count, missed}, 24'd0);

        // Init sequence
        acc_q.push_back(acc(2'd2, 1'b1, 32'd1));
        acc_q.push_back(acc(2'd3, 1'b1, 32'd0));
        reset_n = 1'b1;
        enable  = 1'b1;
        tick(3);
        check("init_busy", busy, 1'b0);
        check("init_done", 35'(acc_q.size()), 35'd0);
        check("init_mask", s_mask, 32'd1);

        // First service, irq dropped mid-sequence, stalled consumer
        s_edge = 1'b1; s_data = 1'b1;
        push_service(1'b1, 1'b1);
        irq_in = 1'b1;
        tick(2);
        irq_in = 1'b0;
        tick(3);
        check("valid_at5", evt_valid, 1'b0);
        tick(1);
        check("valid_at6", evt_valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {evt_valid, evt_data, evt_count}, {1'b1, 2'b11, 16'd0});
            if (i == 3) irq_in = 1'b1;
            if (i == 4) irq_in = 1'b0;
            tick(1);
        end
        check("missed_1", missed, 8'd1);
        evt_ready = 1'b1;
        tick(1);
        check("handshake", {evt_valid, evt_count}, {1'b0, 16'd1});

        // Held level irq is serviced once, then again after a low period
        tick(2);
        s_edge = 1'b1; s_data = 1'b0;
        push_service(1'b1, 1'b0);
        irq_in = 1'b1;
        wait_count(16'd2, "count_2");
        n0 = acc_seen;
        tick(10);
        check("held_no_acc", acc_seen, n0);
        check("held_busy", busy, 1'b1);
        irq_in = 1'b0;
        tick(2);
        s_edge = 1'b0; s_data = 1'b1;
        push_service(1'b0, 1'b1);
        irq_in = 1'b1;
        wait_count(16'd3, "count_3");
        irq_in = 1'b0;
        check("missed_hold", missed, 8'd1);

        // Reset during RD_DATA: no event, init restarts
        tick(2);
        s_edge = 1'b1; s_data = 1'b1;
        acc_q.push_back(acc(2'd3, 1'b0, 32'd0));
        acc_q.push_back(acc(2'd0, 1'b0, 32'd0));
        irq_in = 1'b1;
        tick(4);
        reset_n = 1'b0;
        irq_in  = 1'b0;
        #1;
        check("abort_out", {m_chipselect, m_write_n, busy, evt_valid}, {1'b0, 1'b1, 1'b0, 1'b0});
        check("abort_cnt", {evt_count, missed}, 24'd0);
        acc_q.push_back(acc(2'd2, 1'b1, 32'd1));
        acc_q.push_back(acc(2'd3, 1'b1, 32'd0));
        tick(2);
        reset_n = 1'b1;
        tick(5);
        check("abort_acc_done", 35'(acc_q.size()), 35'd0);
        check("abort_no_evt", {evt_valid, evt_count}, {1'b0, 16'd0});

        // enable gating
        enable = 1'b0;
        irq_in = 1'b1;
        n0 = acc_seen;
        tick(8);
        check("disabled_no_acc", acc_seen, n0);
        check("disabled_busy", busy, 1'b0);
        s_edge = 1'b0; s_data = 1'b0;
        push_service(1'b0, 1'b0);
        evt_ready = 1'b0;
        enable = 1'b1;
        ts_exp = tb_cyc;
        tick(1);
        check("enable_rd_edge", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b1, 2'd3});
        enable = 1'b0;
        irq_in = 1'b0;
        n0 = 0;
        while (!evt_valid && n0 < 40) begin
            tick(1);
            n0++;
        end
        check("mid_disable_valid", evt_valid, 1'b1);
`ifdef PIO_SVC_TIMESTAMP_EN
        check("timestamp", evt_timestamp, ts_exp);
`endif
        evt_ready = 1'b1;
        wait_count(16'd1, "count_after_reset");

        tick(3);
        check("acc_q_empty", 35'(acc_q.size()), 35'd0);
        check("evt_q_empty", 35'(evt_q.size()), 35'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
